// File: rtl/adc_lvds_pkg.sv
// adc_lvds_pkg: mode encodings and frame pattern shared by the ADC serial TX emulator and the aligner
package adc_lvds_pkg;

    typedef enum logic [1:0] {
        MODE_SAMPLE = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_FIXED  = 2'd2,
        MODE_CHECK  = 2'd3
    } modeT;

    localparam logic [15:0] FRM_PATTERN_DEFAULT = 16'b0011111110000000;

endpackage

// File: rtl/adc_tx_sample_fifo.sv
// adc_tx_sample_fifo: 2-entry sample buffer with registered count-based Full/Empty
//   EmuClk, EmuRst_n : clock, asynchronous active-low reset
//   WrEn, WrData     : push (ignored while Full)
//   RdEn, RdData     : pop (ignored while Empty), RdData shows the head
//   Full, Empty      : occupancy flags from the registered count
module adc_tx_sample_fifo #(
    parameter int Width = 28
) (
    input  logic             EmuClk,
    input  logic             EmuRst_n,
    input  logic             WrEn,
    input  logic [Width-1:0] WrData,
    input  logic             RdEn,
    output logic [Width-1:0] RdData,
    output logic             Full,
    output logic             Empty
);

    logic [Width-1:0] mem [2];
    logic             wrPtr, rdPtr, doWr, doRd;
    logic [1:0]       count;

    assign Full   = count == 2'd2;
    assign Empty  = count == 2'd0;
    assign doWr   = WrEn && !Full;
    assign doRd   = RdEn && !Empty;
    assign RdData = mem[rdPtr];

    always_ff @(posedge EmuClk or negedge EmuRst_n) begin
        if (!EmuRst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (doWr) begin
                mem[wrPtr] <= WrData;
                wrPtr      <= ~wrPtr;
            end
            if (doRd) rdPtr <= ~rdPtr;
            count <= count + 2'(doWr) - 2'(doRd);
        end
    end

endmodule

// File: rtl/adc_lvds_tx_emulator.sv
// adc_lvds_tx_emulator: multi-lane ADC serial transmitter model with frame line and word-phase slip
//   EmuClk, EmuRst_n : bit clock, asynchronous active-low reset
//   Enable, Mode     : transmit enable, word source (sample/ramp/fixed/checkerboard)
//   SlipOffset       : word rotation latched at each word load
//   SampleData/Valid/Ready : parallel sample handshake into a 2-entry buffer
//   FrmOut, DataOut, WordStart : registered serial outputs
//   UnderrunCnt      : saturating count of empty-buffer loads in sample mode
module adc_lvds_tx_emulator
    import adc_lvds_pkg::*;
#(
    parameter int          AdcBits    = 14,
    parameter logic [15:0] FrmPattern = FRM_PATTERN_DEFAULT,
    parameter int          Lanes      = 2,
    parameter logic [13:0] TestWord   = 14'h2A5C
) (
    input  logic                     EmuClk,
    input  logic                     EmuRst_n,
    input  logic                     Enable,
    input  logic [1:0]               Mode,
    input  logic [3:0]               SlipOffset,
    input  logic [Lanes*AdcBits-1:0] SampleData,
    input  logic                     SampleValid,
    output logic                     SampleReady,
    output logic                     FrmOut,
    output logic [Lanes-1:0]         DataOut,
    output logic                     WordStart,
    output logic [7:0]               UnderrunCnt
);

    localparam logic [AdcBits-1:0] FrmBits  = FrmPattern[AdcBits-1:0];
    localparam logic [AdcBits-1:0] TestBits = TestWord[AdcBits-1:0];

    logic [Lanes*AdcBits-1:0] shiftWord, nextWord, fifoData;
    logic [AdcBits-1:0]       ramp;
    logic [3:0]               bitCnt, offset, j, pos;
    logic [4:0]               sum;
    logic [Lanes-1:0]         dataBits;
    logic                     running, checkPhase, fifoFull, fifoEmpty, loadNow, popReq;

    adc_tx_sample_fifo #(.Width(Lanes*AdcBits)) sampleFifo (
        .EmuClk  (EmuClk),
        .EmuRst_n(EmuRst_n),
        .WrEn    (SampleValid),
        .WrData  (SampleData),
        .RdEn    (popReq),
        .RdData  (fifoData),
        .Full    (fifoFull),
        .Empty   (fifoEmpty)
    );

    assign SampleReady = !fifoFull;
    // running is low on the first enabled cycle after reset/idle: that edge loads a word without emitting a bit
    assign loadNow     = Enable && (!running || bitCnt == 4'(AdcBits-1));
    assign popReq      = loadNow && Mode == MODE_SAMPLE;
    assign nextWord    = Mode == MODE_SAMPLE ? (fifoEmpty ? '0 : fifoData) :
                         Mode == MODE_RAMP   ? {Lanes{ramp}} :
                         Mode == MODE_FIXED  ? {Lanes{TestBits}} :
                         checkPhase          ? '0 : '1;

    // Rotated bit position: cycle i emits bit AdcBits-1-((i+offset) mod AdcBits)
    assign sum = {1'b0, bitCnt} + {1'b0, offset};
    assign j   = sum >= 5'(AdcBits) ? 4'(sum - 5'(AdcBits)) : sum[3:0];
    assign pos = 4'(AdcBits-1) - j;

    always_comb begin
        dataBits = '0;
        for (int k = 0; k < Lanes; k++) dataBits[k] = shiftWord[k*AdcBits + int'(pos)];
    end

    always_ff @(posedge EmuClk or negedge EmuRst_n) begin
        if (!EmuRst_n) begin
            shiftWord   <= '0;
            ramp        <= '0;
            bitCnt      <= '0;
            offset      <= '0;
            running     <= 1'b0;
            checkPhase  <= 1'b0;
            FrmOut      <= 1'b0;
            DataOut     <= '0;
            WordStart   <= 1'b0;
            UnderrunCnt <= '0;
        end else if (!Enable) begin
            bitCnt     <= '0;
            running    <= 1'b0;
            checkPhase <= 1'b0;
            FrmOut     <= 1'b0;
            DataOut    <= '0;
            WordStart  <= 1'b0;
        end else begin
            running <= 1'b1;
            if (running) begin
                DataOut   <= dataBits;
                FrmOut    <= FrmBits[pos];
                WordStart <= bitCnt == 4'd0;
                bitCnt    <= bitCnt == 4'(AdcBits-1) ? 4'd0 : bitCnt + 4'd1;
            end
            if (loadNow) begin
                shiftWord <= nextWord;
                offset    <= int'(SlipOffset) >= AdcBits ? 4'd0 : SlipOffset;
                if (Mode == MODE_RAMP) ramp <= ramp + AdcBits'(1);
                if (Mode == MODE_CHECK) checkPhase <= ~checkPhase;
                if (Mode == MODE_SAMPLE && fifoEmpty && UnderrunCnt != 8'hFF) UnderrunCnt <= UnderrunCnt + 8'd1;
            end
        end
    end

endmodule
